// File: rtl/stopwatch_counter.sv
// Stopwatch control stage: synchronizes and debounces the front-panel inputs,
// sequences IDLE/RUN/PAUSE, and steps a wrapping 16-bit count at a prescaled rate.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV        = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned MAX_COUNT       = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        up_down,
  output logic [15:0] counter_data,
  output logic        running,
  output logic        wrap_pulse
);

  localparam int unsigned PRE_W = 24;
  localparam int unsigned DEB_W = 20;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NBTN  = 2;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Bit order in the synchronizer: {up_down, btn_clear, btn_start}
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [NBTN-1:0]  level;
  logic [NBTN-1:0]  level_q;
  logic [NBTN-1:0]  press;
  logic [DEB_W-1:0] deb_cnt [NBTN];

  state_t           state;
  logic [PRE_W-1:0] prescale;
  logic             tick_c;
  logic             up_dir_c;
  logic [CNT_W-1:0] count_next_c;
  logic             wrap_next_c;

  // Two-flop synchronizers, per-button debounce, and registered press strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      press   <= '0;
      for (int i = 0; i < NBTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1   <= {up_down, btn_clear, btn_start};
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= ~level[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign up_dir_c = sync2[2];
  assign tick_c   = (state == RUN) && (prescale == PRE_LAST);

  // Next count for a tick, wrapping at MAX_COUNT in either direction
  always_comb begin
    count_next_c = counter_data;
    wrap_next_c  = 1'b0;
    if (up_dir_c) begin
      if (counter_data >= CNT_MAX) begin
        count_next_c = '0;
        wrap_next_c  = 1'b1;
      end else begin
        count_next_c = counter_data + CNT_W'(1);
      end
    end else begin
      if (counter_data == '0) begin
        count_next_c = CNT_MAX;
        wrap_next_c  = 1'b1;
      end else begin
        count_next_c = counter_data - CNT_W'(1);
      end
    end
  end

  // Control FSM with prescaler and count; clear overrides every other action
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prescale     <= '0;
      counter_data <= '0;
      running      <= 1'b0;
      wrap_pulse   <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (press[1]) begin
        state        <= IDLE;
        prescale     <= '0;
        counter_data <= '0;
        running      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press[0]) begin
              state    <= RUN;
              prescale <= '0;
              running  <= 1'b1;
            end
          end
          RUN: begin
            if (tick_c) begin
              prescale     <= '0;
              counter_data <= count_next_c;
              wrap_pulse   <= wrap_next_c;
            end else begin
              prescale <= prescale + PRE_W'(1);
            end
            if (press[0]) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: begin
            if (press[0]) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: a directed vector table for the timing corners,
// then random button/switch/reset activity checked against an event-level model.
module tb_stopwatch_counter;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int MX = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_start;
  logic        btn_clear;
  logic        up_down;
  logic [15:0] counter_data;
  logic        running;
  logic        wrap_pulse;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB),
    .MAX_COUNT      (MX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .up_down     (up_down),
    .counter_data(counter_data),
    .running     (running),
    .wrap_pulse  (wrap_pulse)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: inputs seen two edges late, a button is accepted after DB
  // consecutive differing samples, and its action lands two edges later.
  int m_cnt   = 0;
  int m_phase = 0;
  int m_mode  = 0;  // 0 idle, 1 run, 2 pause
  bit m_wrap  = 0;
  bit hist [3][2];
  bit lv [2];
  int rn [2];
  int due [2];

  always @(posedge clk) begin
    bit act [2];
    bit rawv [3];
    bit dir;
    int nxt;
    rawv[0] = btn_start;
    rawv[1] = btn_clear;
    rawv[2] = up_down;
    if (reset) begin
      m_cnt = 0; m_phase = 0; m_mode = 0; m_wrap = 0;
      for (int b = 0; b < 3; b++) begin hist[b][0] = 0; hist[b][1] = 0; end
      for (int b = 0; b < 2; b++) begin lv[b] = 0; rn[b] = 0; due[b] = 0; end
    end else begin
      for (int b = 0; b < 2; b++) begin
        act[b] = (due[b] == 1);
        if (due[b] > 0) due[b]--;
      end
      dir = hist[2][0];
      m_wrap = 0;
      if (act[1]) begin
        m_mode = 0; m_cnt = 0; m_phase = 0;
      end else if (m_mode == 1) begin
        m_phase = (m_phase + 1) % TD;
        if (m_phase == 0) begin
          if (dir) begin
            nxt = (m_cnt + 1) % (MX + 1);
            m_wrap = (nxt == 0);
          end else begin
            nxt = (m_cnt + MX) % (MX + 1);
            m_wrap = (m_cnt == 0);
          end
          m_cnt = nxt;
        end
        if (act[0]) m_mode = 2;
      end else if (act[0]) begin
        if (m_mode == 0) m_phase = 0;
        m_mode = 1;
      end
      for (int b = 0; b < 2; b++) begin
        if (hist[b][0] != lv[b]) begin
          rn[b]++;
          if (rn[b] == DB) begin
            lv[b] = ~lv[b];
            rn[b] = 0;
            if (lv[b]) due[b] = 2;
          end
        end else begin
          rn[b] = 0;
        end
      end
      for (int b = 0; b < 3; b++) begin
        hist[b][0] = hist[b][1];
        hist[b][1] = rawv[b];
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    check("model_cnt", int'(counter_data), m_cnt);
    check("model_run", int'(running), int'(m_mode == 1));
    check("model_wrap", int'(wrap_pulse), int'(m_wrap));
  end

  typedef struct {
    string name;
    int    adv;
    int    cnt;
    bit    run;
    bit    wrap;
    bit    st;
    bit    cl;
    bit    ud;
    bit    rst;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string n, int a, int c, bit r, bit w,
                              bit s, bit cl, bit u, bit rs);
    vec_t v;
    v.name = n; v.adv = a; v.cnt = c; v.run = r; v.wrap = w;
    v.st = s; v.cl = cl; v.ud = u; v.rst = rs;
    tbl.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; up_down = 1'b1;

    // name, advance, exp cnt/run/wrap, then inputs start/clear/ud/reset
    add("reset",         2, 0, 0, 0, 0, 0, 1, 0);
    add("idle",          1, 0, 0, 0, 1, 0, 1, 0);
    add("deb_e4",        5, 0, 0, 0, 1, 0, 1, 0);
    add("deb_e5",        1, 0, 0, 0, 1, 0, 1, 0);
    add("run_e6",        1, 0, 1, 0, 1, 0, 1, 0);
    add("tick1_pre",     3, 0, 1, 0, 0, 0, 1, 0);
    add("tick1",         1, 1, 1, 0, 0, 0, 1, 0);
    add("tick2_pre",     3, 1, 1, 0, 0, 0, 1, 0);
    add("tick2",         1, 2, 1, 0, 0, 0, 1, 0);
    add("pause_btn",     3, 2, 1, 0, 1, 0, 1, 0);
    add("pause_rel",     4, 3, 1, 0, 0, 0, 1, 0);
    add("pause_pre",     2, 4, 1, 0, 0, 0, 1, 0);
    add("pause",         1, 4, 0, 0, 0, 0, 1, 0);
    add("frozen",       10, 4, 0, 0, 0, 0, 1, 0);
    add("resume_btn",    3, 4, 0, 0, 1, 0, 1, 0);
    add("resume_rel",    4, 4, 0, 0, 0, 0, 1, 0);
    add("frozen2",       2, 4, 0, 0, 0, 0, 1, 0);
    add("resume",        1, 4, 1, 0, 0, 0, 1, 0);
    add("resume_p1",     1, 4, 1, 0, 0, 0, 1, 0);
    add("resume_tick",   1, 5, 1, 0, 0, 0, 1, 0);
    add("at_eight",     12, 8, 1, 0, 0, 0, 1, 0);
    add("at_nine",       4, 9, 1, 0, 0, 0, 1, 0);
    add("nine_hold",     3, 9, 1, 0, 0, 0, 1, 0);
    add("wrap_up",       1, 0, 1, 1, 0, 0, 1, 0);
    add("wrap_up_end",   1, 0, 1, 0, 0, 0, 0, 0);
    add("dir_sync",      2, 0, 1, 0, 0, 0, 0, 0);
    add("wrap_down",     1, 9, 1, 1, 0, 0, 0, 0);
    add("wrap_dn_end",   1, 9, 1, 0, 0, 0, 0, 0);
    add("both_btn",     10, 7, 1, 0, 1, 1, 0, 0);
    add("both_rel",      4, 6, 1, 0, 0, 0, 0, 0);
    add("at_five",       2, 5, 1, 0, 0, 0, 0, 0);
    add("clear_wins",    1, 0, 0, 0, 0, 0, 0, 0);
    add("idle_hold",     6, 0, 0, 0, 1, 0, 0, 0);
    add("restart_btn",   4, 0, 0, 0, 0, 1, 0, 0);
    add("restart_pre",   2, 0, 0, 0, 0, 1, 0, 0);
    add("restart",       1, 0, 1, 0, 0, 1, 0, 0);
    add("pre_tick",      3, 0, 1, 0, 0, 0, 0, 0);
    add("clear_on_tick", 1, 0, 0, 0, 1, 0, 1, 0);
    add("run3_btn",      4, 0, 0, 0, 0, 0, 1, 0);
    add("run3_pre",      2, 0, 0, 0, 0, 0, 1, 0);
    add("run3",          1, 0, 1, 0, 0, 0, 1, 0);
    add("at_six",       27, 6, 1, 0, 1, 0, 1, 0);
    add("at_seven",      1, 7, 1, 0, 1, 0, 1, 0);
    add("pre_reset",     2, 7, 1, 0, 1, 0, 1, 1);
    add("mid_reset",     1, 0, 0, 0, 1, 0, 1, 0);
    add("redeb_pre",     6, 0, 0, 0, 1, 0, 1, 0);
    add("redeb_run",     1, 0, 1, 0, 0, 0, 1, 0);
    add("redeb_tick",    4, 1, 1, 0, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      repeat (tbl[i].adv) begin
        @(posedge clk);
        #1;
      end
      check({tbl[i].name, "_cnt"}, int'(counter_data), tbl[i].cnt);
      check({tbl[i].name, "_run"}, int'(running), int'(tbl[i].run));
      check({tbl[i].name, "_wrap"}, int'(wrap_pulse), int'(tbl[i].wrap));
      btn_start = tbl[i].st;
      btn_clear = tbl[i].cl;
      up_down   = tbl[i].ud;
      reset     = tbl[i].rst;
    end

    // Random activity with bounce-like toggling and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(7) == 0)   btn_start = ~btn_start;
      if ($urandom_range(39) == 0)  btn_clear = ~btn_clear;
      if ($urandom_range(29) == 0)  up_down   = ~up_down;
      reset = ($urandom_range(599) == 0);
    end

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
